// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int          WORD_W  = 32;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// In-order queue of fetched {instr, pc} entries; flush has priority over push/pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  fetch_entry_t           i_data,
  input  logic                   i_pop,
  output fetch_entry_t           o_head,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  fetch_entry_t     r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Head is read straight from storage, so a write is visible the cycle after.
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: PC generation, memory credit/discard tracking, in-order queue.
// Optional FETCH_PERF_EN adds saturating stall and discard counters.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH           = 4,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          MAX_OUTSTANDING = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   imem_req_valid,
  output logic [31:0]            imem_req_addr,
  input  logic                   imem_req_ready,
  input  logic                   imem_rsp_valid,
  input  logic [31:0]            imem_rsp_data,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  output logic                   inst_valid,
  output logic [31:0]            inst_data,
  output logic [31:0]            inst_pc,
  output logic [31:0]            inst_pc_plus4,
  input  logic                   inst_ready,
  output logic [$clog2(DEPTH):0] count
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]            perf_stall_cycles,
  output logic [31:0]            perf_discards
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = CW + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;

  logic          r_active;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_rsp_pc;
  logic [OW-1:0] r_outstanding;
  logic [OW-1:0] r_discard;

  logic [CW-1:0] w_count;
  logic          w_full;
  logic          w_empty;
  fetch_entry_t  w_head;
  fetch_entry_t  w_push_entry;
  logic [SW-1:0] w_credit_used;
  logic          w_can_issue;
  logic          w_req_fire;
  logic          w_keep;
  logic          w_pop;
  logic [31:0]   w_redirect_pc;

  // Handshakes: a transfer happens on a cycle where valid and ready are both 1;
  // an offered request holds its address until accepted or superseded by a redirect.
  assign w_credit_used  = {1'b0, w_count} + SW'(r_outstanding);
  assign w_can_issue    = r_active && (w_credit_used < SW'(DEPTH)) &&
                          (r_outstanding < OW'(MAX_OUTSTANDING));
  assign imem_req_valid = w_can_issue && !redirect_valid;
  assign imem_req_addr  = r_fetch_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;
  assign w_keep         = imem_rsp_valid && !redirect_valid && (r_discard == '0);
  assign w_pop          = inst_valid && inst_ready;
  assign w_redirect_pc  = redirect_pc & ~32'h3;
  assign w_push_entry   = '{instr: imem_rsp_data, pc: r_rsp_pc};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (redirect_valid),
    .i_push  (w_keep),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active      <= 1'b0;
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      r_active      <= 1'b1;
      r_outstanding <= r_outstanding + OW'(w_req_fire) - OW'(imem_rsp_valid);
      if (redirect_valid) begin
        // Everything still in flight after this cycle's response is stale.
        r_fetch_pc <= w_redirect_pc;
        r_rsp_pc   <= w_redirect_pc;
        r_discard  <= r_outstanding - OW'(imem_rsp_valid);
      end else begin
        if (w_req_fire) r_fetch_pc <= r_fetch_pc + PC_STEP;
        if (imem_rsp_valid) begin
          if (r_discard != '0) r_discard <= r_discard - 1'b1;
          else                 r_rsp_pc  <= r_rsp_pc + PC_STEP;
        end
      end
    end
  end

  assign inst_valid    = !w_empty;
  assign inst_data     = w_head.instr;
  assign inst_pc       = w_head.pc;
  assign inst_pc_plus4 = w_head.pc + PC_STEP;
  assign count         = w_count;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(w_keep && w_full));

`ifdef FETCH_PERF_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_discards;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
      r_discards     <= '0;
    end else begin
      if (!inst_valid && (r_stall_cycles != '1)) r_stall_cycles <= r_stall_cycles + 1'b1;
      if (imem_rsp_valid && !w_keep && (r_discards != '1)) r_discards <= r_discards + 1'b1;
    end
  end

  assign perf_stall_cycles = r_stall_cycles;
  assign perf_discards     = r_discards;
`endif

endmodule
